// File: rtl/hub75_rx_monitor.sv
// hub75_rx_monitor: rebuilds shifted HUB75 rows into parallel words and flags protocol violations
module hub75_rx_monitor #(
  parameter int NUM_COLS    = 64,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  bit_clk_in,
  input  logic                  lat_in,
  input  logic                  oe_in,
  input  logic [3:0]            addr_in,
  input  logic [5:0]            rgb_in,
  output logic [6*NUM_COLS-1:0] row_out,
  output logic [3:0]            row_addr_out,
  output logic                  row_valid_out,
  input  logic                  row_ready_in,
  output logic                  len_err_out,
  output logic                  shift_in_lat_out,
  output logic                  timeout_out,
  output logic                  overrun_out,
  output logic                  oe_during_shift_out
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;
  state_t state, state_nx;
  logic [12:0] sync [SYNC_STAGES];
  logic [12:0] s;
  logic bclk_d, lat_d, bclk_rise, lat_rise, timeout;
  logic [6*NUM_COLS-1:0] sr;
  logic [7:0] cnt;
  logic [TW-1:0] tcnt;
  logic [3:0] addr_lat;
  // s = {bclk, lat, oe, addr[3:0], rgb[5:0]}, all from the same synchroniser stage
  assign s = sync[SYNC_STAGES-1];
  assign bclk_rise = s[12] & ~bclk_d;
  assign lat_rise = s[11] & ~lat_d;
  assign timeout = state == SHIFT && !bclk_rise && !lat_rise && tcnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      bclk_d <= 1'b0;
      lat_d <= 1'b0;
    end else begin
      sync[0] <= {bit_clk_in, lat_in, oe_in, addr_in, rgb_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      bclk_d <= s[12];
      lat_d <= s[11];
    end
  end
  always_ff @(posedge clk_in) state <= reset_in ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (lat_rise && state != CAPTURE) ? CAPTURE :
               timeout ? IDLE :
               state == CAPTURE ? (bclk_rise ? SHIFT : IDLE) :
               bclk_rise ? SHIFT : state;
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sr <= '0;
      cnt <= '0;
      tcnt <= '0;
      addr_lat <= '0;
      row_out <= '0;
      row_addr_out <= '0;
      row_valid_out <= 1'b0;
      len_err_out <= 1'b0;
      shift_in_lat_out <= 1'b0;
      timeout_out <= 1'b0;
      overrun_out <= 1'b0;
      oe_during_shift_out <= 1'b0;
    end else begin
      len_err_out <= 1'b0;
      shift_in_lat_out <= bclk_rise & s[11];
      timeout_out <= timeout;
      tcnt <= (state == SHIFT && !bclk_rise) ? tcnt + 1'b1 : '0;
      if (state == SHIFT && !s[10]) oe_during_shift_out <= 1'b1;
      if (lat_rise) addr_lat <= s[9:6];
      if (timeout) sr <= '0;
      else if (bclk_rise)
        for (int i = 0; i < 6; i++) sr[i*NUM_COLS +: NUM_COLS] <= {sr[i*NUM_COLS +: NUM_COLS-1], s[i]};
      // an edge landing in the capture cycle belongs to the next row
      if (timeout) cnt <= '0;
      else if (state == CAPTURE) cnt <= {7'd0, bclk_rise};
      else if (bclk_rise && cnt != 8'hff) cnt <= cnt + 8'd1;
      if (state == CAPTURE) begin
        row_out <= sr;
        row_addr_out <= addr_lat;
        row_valid_out <= 1'b1;
        len_err_out <= cnt != 8'(NUM_COLS);
        if (row_valid_out && !row_ready_in) overrun_out <= 1'b1;
      end else if (row_valid_out && row_ready_in) row_valid_out <= 1'b0;
    end
  end
endmodule
